ad_frame_unpack: RTL and testbench
==================================

# ad_frame_unpack

Downstream consumer of the ADC sample FIFO written by the AD7606 read controller. It pops 18-bit tagged words from the FIFO with single-outstanding reads and checks the frame tags: bits [17:16] are 01 for the first word, 00 for the middle words and 10 for the last word. Each complete 6-channel frame is presented on a parallel valid/ready bus for the processing/uplink stage, and framing errors are counted and resynchronised.

## Interface
- FRAME_WORDS, 6, words per frame; ch0 carries the start tag, ch5 the end tag.
- DATA_W, 16, sample width; FIFO word width is DATA_W+2.
- ERR_W, 8, width of the saturating error counter.

- clk  in  1  system clock, single clock domain (20 MHz).
- resetn  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rden  out  1  FIFO read strobe; combinational from fifo_empty and registered state.
- fifo_rdata  in  DATA_W+2  FIFO read data, valid the cycle after fifo_rden.
- out_valid  out  1  frame available; held until accepted.
- out_ready  in  1  consumer accepts the frame when high with out_valid.
- ch_data  out  FRAME_WORDS*DATA_W  ch0 at [DATA_W-1:0], ch5 at the top bits; stable while out_valid.
- sync_err  out  1  one-cycle pulse per framing error.
- err_cnt  out  ERR_W  framing errors since reset; saturates at all-ones.

## Operation
- Reset values: fifo_rden 0, out_valid 0, ch_data 0, sync_err 0, err_cnt 0. State is HUNT, idx 0, rd_pend 0.
- Read rule: fifo_rden = !fifo_empty && !rd_pend && state != PRESENT. rd_pend is set the cycle after fifo_rden. While rd_pend is high, fifo_rdata is evaluated, so throughput is one word per 2 cycles.
- Word evaluation happens only when rd_pend is high. Define tag = fifo_rdata[17:16].
- HUNT state:
  - tag 01: store ch0, idx=1, go to COLLECT.
  - Any other tag: discard silently; not counted as an error.
- COLLECT state, idx 1..FRAME_WORDS-2:
  - tag 00: store ch[idx], idx++.
  - tag 01: sync_err; store as ch0, idx=1, stay in COLLECT.
  - tag 10 or 11: sync_err, go to HUNT.
- COLLECT state, idx FRAME_WORDS-1:
  - tag 10: store ch5, go to PRESENT.
  - tag 01: sync_err, restart as above.
  - tag 00 or 11: sync_err, go to HUNT.
- ch_data registers load only on accepted words. Partially collected words are never visible, because out_valid is low outside PRESENT.
- PRESENT state: out_valid=1 and no FIFO reads. On out_valid && out_ready, go to HUNT; out_valid drops on the next edge.
- err_cnt increments by 1 per sync_err and holds at 2^ERR_W-1.
- Reset mid-operation: all state and outputs return to reset values immediately; the partial frame is lost. A pending read's data is dropped, and the first word after reset is read fresh.

## Timing
- Word k read: fifo_rden at cycle t, data sampled at the edge ending t+1, next fifo_rden no earlier than t+2.
- Frame latency: the 6th word's fifo_rden at cycle t gives out_valid=1 and updated ch_data in cycle t+2.
- Minimum frame period is 12 cycles of reading + 1 cycle PRESENT handshake = 13 cycles with out_ready held high. The producer needs ~70 cycles per frame, so the FIFO drains.
- out_ready low stalls indefinitely; FIFO backpressure then comes from the producer's almost-full check.
- sync_err is registered and asserted the cycle after the offending word is sampled. err_cnt updates on the same edge.
- The fifo_empty → fifo_rden path is combinational; the FIFO must tolerate same-cycle empty-based read gating.

## Structure
- Shared package ad_pkg holds:
  - TAG_START=2'b01, TAG_MID=2'b00, TAG_END=2'b10.
  - FRAME_WORDS, DATA_W.
  - The state enum: HUNT, COLLECT, PRESENT, one-hot.
- The AD7606 read controller imports the same tag constants.
- Single module; no sub-module warranted. Tag checking and the read strobe are small enough to stay inline.

## Test plan
- Clean frame: FIFO holds 0x10001, 0x00002 … 0x00005, 0x20006 with out_ready=1 → out_valid one cycle, ch_data = {6,5,4,3,2,1}; err_cnt stays 0; fifo_rden pulses every 2 cycles.
- Leading garbage: 0x00AAA, 0x20BBB, then a clean frame → both garbage words discarded, frame correct, err_cnt 0.
- Restart mid-frame: 0x10001, 0x00002, 0x10011, then 0x00012..0x00015, 0x20016 → sync_err once, ch_data = {16,15,14,13,12,11}, err_cnt 1.
- Missing end tag: 6th word 0x00006 → sync_err, state HUNT, no out_valid; the next clean frame is delivered.
- Backpressure: two frames queued, out_ready low for 50 cycles → first frame held stable, no fifo_rden during the hold; after out_ready rises, the second frame arrives 13 cycles later.
- Saturation and reset: 300 bad-end frames → err_cnt = 0xFF. Assert resetn low mid-COLLECT → all outputs 0 and the next clean frame is delivered.

Source files
------------

// File: rtl/ad_pkg.sv
// ad_pkg: frame tags, frame geometry and unpacker states shared by the AD7606 sample path
package ad_pkg;
  localparam int FRAME_WORDS = 6;
  localparam int DATA_W = 16;
  localparam logic [1:0] TAG_START = 2'b01;
  localparam logic [1:0] TAG_MID = 2'b00;
  localparam logic [1:0] TAG_END = 2'b10;
  typedef enum logic [2:0] {
    HUNT    = 3'b001,
    COLLECT = 3'b010,
    PRESENT = 3'b100
  } state_t;
endpackage

// File: rtl/ad_frame_unpack.sv
// ad_frame_unpack: pops tagged ADC words one at a time, rebuilds 6-channel frames
// and presents them on a valid/ready bus, counting and resynchronising framing errors.
module ad_frame_unpack #(
  parameter int FRAME_WORDS = ad_pkg::FRAME_WORDS,
  parameter int DATA_W = ad_pkg::DATA_W,
  parameter int ERR_W = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          fifo_empty,
  output logic                          fifo_rden,
  input  logic [DATA_W+1:0]             fifo_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FRAME_WORDS*DATA_W-1:0] ch_data,
  output logic                          sync_err,
  output logic [ERR_W-1:0]              err_cnt
);
  import ad_pkg::*;
  localparam int IDX_W = $clog2(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_WORDS - 1);
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n, wr_idx;
  logic rd_pend, wr_en, err, last;
  logic [1:0] tag;
  assign tag = fifo_rdata[DATA_W+1:DATA_W];
  assign last = idx == LAST;
  // resetn gating keeps the strobe low while held in reset so no word is lost
  assign fifo_rden = resetn && !fifo_empty && !rd_pend && state != PRESENT;
  assign out_valid = state == PRESENT;
  always_comb begin
    state_n = state;
    idx_n = idx;
    wr_idx = idx;
    wr_en = 1'b0;
    err = 1'b0;
    if (state == PRESENT) begin
      state_n = out_ready ? HUNT : PRESENT;
    end else if (rd_pend) begin
      if (tag == TAG_START) begin
        err = state == COLLECT;
        wr_en = 1'b1;
        wr_idx = '0;
        idx_n = IDX_W'(1);
        state_n = COLLECT;
      end else if (state == COLLECT) begin
        if (tag == (last ? TAG_END : TAG_MID)) begin
          wr_en = 1'b1;
          idx_n = last ? '0 : idx + 1'b1;
          state_n = last ? PRESENT : COLLECT;
        end else begin
          err = 1'b1;
          idx_n = '0;
          state_n = HUNT;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= HUNT;
    else state <= state_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      idx <= '0;
      rd_pend <= 1'b0;
      ch_data <= '0;
      sync_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      idx <= idx_n;
      rd_pend <= fifo_rden;
      sync_err <= err;
      if (wr_en) ch_data[32'(wr_idx)*DATA_W +: DATA_W] <= fifo_rdata[DATA_W-1:0];
      if (err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ad_frame_unpack.sv
// tb_ad_frame_unpack: directed scenarios against a registered-read FIFO model
module tb_ad_frame_unpack;
  localparam int FW = 6;
  localparam int DW = 16;
  localparam int EW = 8;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic out_ready = 1'b1;
  logic fifo_empty, fifo_rden, out_valid, sync_err;
  logic [DW+1:0] fifo_rdata = '0;
  logic [FW*DW-1:0] ch_data, cap;
  logic [EW-1:0] err_cnt;
  logic [DW+1:0] mem [0:8191];
  int wp = 0;
  int rp = 0;
  int n_vec = 0;
  int n_bad = 0;
  int n_rden, gap_bad, last_rden, n_valid, first_valid, n_err, first_err;

  ad_frame_unpack dut (
    .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .fifo_rdata(fifo_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .ch_data(ch_data), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #25 clk = ~clk;
  assign fifo_empty = (wp == rp);
  always @(posedge clk)
    if (fifo_rden && wp != rp) begin
      fifo_rdata <= mem[rp];
      rp <= rp + 1;
    end

  task automatic push(input logic [DW+1:0] w);
    mem[wp] = w;
    wp++;
  endtask

  task automatic push_frame(input logic [15:0] b);
    push({2'b01, 16'(b + 16'd1)});
    for (int i = 2; i <= 5; i++) push({2'b00, 16'(b + 16'(i))});
    push({2'b10, 16'(b + 16'd6)});
  endtask

  function automatic logic [FW*DW-1:0] exp_frame(input logic [15:0] b);
    logic [FW*DW-1:0] r;
    for (int i = 0; i < FW; i++) r[i*DW +: DW] = 16'(b + 16'(i + 1));
    return r;
  endfunction

  task automatic observe(input int n);
    n_rden = 0; gap_bad = 0; last_rden = -1; n_valid = 0;
    first_valid = -1; n_err = 0; first_err = -1; cap = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fifo_rden) begin
        if (last_rden >= 0 && i - last_rden != 2) gap_bad++;
        last_rden = i;
        n_rden++;
      end
      if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = i;
          cap = ch_data;
        end
        n_valid++;
      end
      if (sync_err) begin
        if (first_err < 0) first_err = i;
        n_err++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (fifo_rden !== 1'b0) begin n_bad++; $display("FAIL reset_rden got %b exp 0", fifo_rden); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_vec++; if (ch_data !== '0) begin n_bad++; $display("FAIL reset_ch_data got %h exp 0", ch_data); end
    n_vec++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL reset_sync_err got %b exp 0", sync_err); end
    n_vec++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_err_cnt got %h exp 00", err_cnt); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean();
    @(posedge clk); #1;
    push_frame(16'h0000);
    observe(30);
    n_vec++; if (n_rden != 6) begin n_bad++; $display("FAIL clean_rden_count got %0d exp 6", n_rden); end
    n_vec++; if (gap_bad != 0) begin n_bad++; $display("FAIL clean_rden_spacing got %0d bad gaps exp 0", gap_bad); end
    n_vec++; if (n_valid != 1) begin n_bad++; $display("FAIL clean_valid_cycles got %0d exp 1", n_valid); end
    n_vec++; if (first_valid - last_rden != 2) begin n_bad++; $display("FAIL clean_latency got %0d exp 2", first_valid - last_rden); end
    n_vec++; if (cap !== exp_frame(16'h0000)) begin n_bad++; $display("FAIL clean_ch_data got %h exp %h", cap, exp_frame(16'h0000)); end
    n_vec++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL clean_err_cnt got %h exp 00", err_cnt); end
    n_vec++; if (n_err != 0) begin n_bad++; $display("FAIL clean_sync_err got %0d exp 0", n_err); end
  endtask

  task automatic test_garbage();
    @(posedge clk); #1;
    push(18'h00AAA);
    push(18'h20BBB);
    push_frame(16'h0020);
    observe(40);
    n_vec++; if (n_rden != 8) begin n_bad++; $display("FAIL garbage_rden_count got %0d exp 8", n_rden); end
    n_vec++; if (n_valid != 1) begin n_bad++; $display("FAIL garbage_valid_cycles got %0d exp 1", n_valid); end
    n_vec++; if (cap !== exp_frame(16'h0020)) begin n_bad++; $display("FAIL garbage_ch_data got %h exp %h", cap, exp_frame(16'h0020)); end
    n_vec++; if (err_cnt !== 8'h00 || n_err != 0) begin n_bad++; $display("FAIL garbage_errors got cnt %h pulses %0d exp 00/0", err_cnt, n_err); end
  endtask

  task automatic test_restart();
    @(posedge clk); #1;
    push(18'h10001);
    push(18'h00002);
    push_frame(16'h0010);
    observe(40);
    n_vec++; if (n_err != 1) begin n_bad++; $display("FAIL restart_sync_err got %0d exp 1", n_err); end
    n_vec++; if (n_valid != 1) begin n_bad++; $display("FAIL restart_valid_cycles got %0d exp 1", n_valid); end
    n_vec++; if (cap !== exp_frame(16'h0010)) begin n_bad++; $display("FAIL restart_ch_data got %h exp %h", cap, exp_frame(16'h0010)); end
    n_vec++; if (err_cnt !== 8'h01) begin n_bad++; $display("FAIL restart_err_cnt got %h exp 01", err_cnt); end
  endtask

  task automatic test_missing_end();
    @(posedge clk); #1;
    push(18'h10001);
    for (int i = 2; i <= 6; i++) push(18'(i));
    observe(30);
    n_vec++; if (n_err != 1) begin n_bad++; $display("FAIL noend_sync_err got %0d exp 1", n_err); end
    n_vec++; if (first_err - last_rden != 2) begin n_bad++; $display("FAIL noend_err_timing got %0d exp 2", first_err - last_rden); end
    n_vec++; if (n_valid != 0) begin n_bad++; $display("FAIL noend_valid_cycles got %0d exp 0", n_valid); end
    n_vec++; if (err_cnt !== 8'h02) begin n_bad++; $display("FAIL noend_err_cnt got %h exp 02", err_cnt); end
    @(posedge clk); #1;
    push_frame(16'h0030);
    observe(30);
    n_vec++; if (n_valid != 1 || cap !== exp_frame(16'h0030)) begin n_bad++; $display("FAIL noend_next_frame got %0d/%h exp 1/%h", n_valid, cap, exp_frame(16'h0030)); end
  endtask

  task automatic test_back_to_back();
    int k;
    int bad;
    out_ready = 1'b0;
    @(posedge clk); #1;
    push_frame(16'h0100);
    push_frame(16'h0200);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 40);
    n_vec++; if (out_valid !== 1'b1 || ch_data !== exp_frame(16'h0100)) begin n_bad++; $display("FAIL bp_first_frame got %b/%h exp 1/%h", out_valid, ch_data, exp_frame(16'h0100)); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || ch_data !== exp_frame(16'h0100) || fifo_rden !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    out_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 40);
    n_vec++; if (k != 13) begin n_bad++; $display("FAIL bp_second_latency got %0d exp 13", k); end
    n_vec++; if (ch_data !== exp_frame(16'h0200)) begin n_bad++; $display("FAIL bp_second_frame got %h exp %h", ch_data, exp_frame(16'h0200)); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept_drop got %b exp 0", out_valid); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_saturation();
    int k;
    @(posedge clk); #1;
    for (int f = 0; f < 300; f++) begin
      push(18'h10000);
      for (int i = 0; i < 5; i++) push(18'h00000);
    end
    k = 0;
    while (wp != rp && k < 5000) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    n_vec++; if (wp != rp) begin n_bad++; $display("FAIL sat_drain got %0d left exp 0", wp - rp); end
    n_vec++; if (err_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_err_cnt got %h exp ff", err_cnt); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    push_frame(16'h0300);
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b exp 0", out_valid); end
    n_vec++; if (ch_data !== '0) begin n_bad++; $display("FAIL rst_mid_ch_data got %h exp 0", ch_data); end
    n_vec++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL rst_mid_err_cnt got %h exp 00", err_cnt); end
    n_vec++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_sync_err got %b exp 0", sync_err); end
    n_vec++; if (fifo_rden !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rden got %b exp 0", fifo_rden); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++; if (err_cnt !== 8'h00 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_leftover got cnt %h valid %b exp 00/0", err_cnt, out_valid); end
    @(posedge clk); #1;
    push_frame(16'h0400);
    observe(30);
    n_vec++; if (n_valid != 1) begin n_bad++; $display("FAIL rst_next_valid got %0d exp 1", n_valid); end
    n_vec++; if (cap !== exp_frame(16'h0400)) begin n_bad++; $display("FAIL rst_next_ch_data got %h exp %h", cap, exp_frame(16'h0400)); end
    n_vec++; if (n_err != 0) begin n_bad++; $display("FAIL rst_next_sync_err got %0d exp 0", n_err); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_garbage();
    test_restart();
    test_missing_end();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
